// File: rtl/hazard_scheduler_if.sv
// Decode-to-issue-control bundle: decoded instruction fields in, stall/issue/forwarding controls out.
interface hazard_scheduler_if #(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              dec_valid;
  logic [REG_AW-1:0] dec_src1;
  logic [REG_AW-1:0] dec_src2;
  logic              dec_use_src2;
  logic [REG_AW-1:0] dec_dst;
  logic              dec_wb;
  logic              dec_mem_read;
  logic              stall;
  logic              bubble;
  logic              issue;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output dec_valid, dec_src1, dec_src2, dec_use_src2, dec_dst, dec_wb, dec_mem_read,
    input  stall, bubble, issue, fwd_sel1, fwd_sel2, stall_count
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src2, dec_use_src2, dec_dst, dec_wb, dec_mem_read,
    output stall, bubble, issue, fwd_sel1, fwd_sel2, stall_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Issue controller: scoreboard of in-flight register writes that stalls decode on RAW hazards.
// Define HAZ_FWD_EN for the forwarding-aware variant (load-use stalls only, fwd_sel outputs).
module hazard_scheduler #(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 3,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  input logic               flush,
  hazard_scheduler_if.slave dec
);
  localparam int FWD_W = 2;

  logic [PIPE_DEPTH-1:0]             v_q, v_d;
  logic [PIPE_DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [PIPE_DEPTH-1:0]             match1_s, match2_s;
  logic                              hazard_s, stall_s, issue_s;
  logic [FWD_W-1:0]                  fwd1_s, fwd2_s;
`ifdef HAZ_FWD_EN
  // Only the execute-stage load flag can create a stall, so older ld flags are not kept.
  logic                              ld_q, ld_d;
`endif

  // Compare decode sources against every valid scoreboard entry (bit 0 = execute stage).
  always_comb begin
    match1_s = '0;
    match2_s = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      match1_s[k] = v_q[k] & (dst_q[k] == dec.dec_src1);
      match2_s[k] = v_q[k] & dec.dec_use_src2 & (dst_q[k] == dec.dec_src2);
    end
  end

  // Hazard decision, forwarding selects and the issue/stall outcome.
  always_comb begin
    hazard_s = 1'b0;
    fwd1_s   = '0;
    fwd2_s   = '0;
`ifdef HAZ_FWD_EN
    hazard_s = ld_q & (match1_s[0] | match2_s[0]);
    // Walk oldest to youngest so the youngest matching producer wins.
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      fwd1_s = match1_s[k] ? FWD_W'(k + 1) : fwd1_s;
      fwd2_s = match2_s[k] ? FWD_W'(k + 1) : fwd2_s;
    end
`else
    hazard_s = |(match1_s | match2_s);
`endif
    stall_s = dec.dec_valid & hazard_s & ~flush;
    issue_s = dec.dec_valid & ~hazard_s & ~flush;
  end

  // Scoreboard shift, flush clear and saturating stall counter.
  always_comb begin
    v_d   = {v_q[PIPE_DEPTH-2:0], issue_s & dec.dec_wb};
    dst_d = {dst_q[PIPE_DEPTH-2:0], dec.dec_dst};
    if (flush) begin
      v_d = '0;
    end else begin
      v_d = {v_q[PIPE_DEPTH-2:0], issue_s & dec.dec_wb};
    end
    if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
`ifdef HAZ_FWD_EN
    ld_d = dec.dec_mem_read;
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q   <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZ_FWD_EN
  // Execute-stage load flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_q <= 1'b0;
    end else begin
      ld_q <= ld_d;
    end
  end
`endif

  assign dec.stall       = stall_s;
  assign dec.bubble      = stall_s;
  assign dec.issue       = issue_s;
  assign dec.fwd_sel1    = (stall_s | flush) ? {FWD_W{1'b0}} : fwd1_s;
  assign dec.fwd_sel2    = (stall_s | flush) ? {FWD_W{1'b0}} : fwd2_s;
  assign dec.stall_count = cnt_q;
endmodule
